// File: rtl/fu_result_buffer_pkg.sv
// Shared CDB definitions: default result/tag widths, the null ROB tag and the
// CDB entry field layout {exception, ROBEN, result} used by all functional units.
package fu_result_buffer_pkg;

  localparam int DATA_W_DEF  = 32;
  localparam int ROBEN_W_DEF = 5;

  // Tag 0 marks "no instruction"; such results are never broadcast.
  localparam logic [ROBEN_W_DEF-1:0] NULL_ROBEN = '0;

  typedef struct packed {
    logic                   exception;
    logic [ROBEN_W_DEF-1:0] roben;
    logic [DATA_W_DEF-1:0]  result;
  } cdb_entry_t;

endpackage

// File: rtl/fu_result_buffer.sv
// In-order result queue between a functional unit and the CDB arbiter.
// Latency: push visible on cdb_valid one cycle later; zero with FU_RESULT_BUFFER_BYPASS_EN on an empty queue.
// Backpressure: in_ready drops only when full (no dependence on cdb_grant); head held until granted.
module fu_result_buffer
  import fu_result_buffer_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ROBEN_W = ROBEN_W_DEF
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            in_result,
  input  logic [ROBEN_W-1:0]           in_ROBEN,
  input  logic                         in_flow,
  output logic                         in_ready,
  output logic                         cdb_valid,
  output logic [DATA_W-1:0]            cdb_result,
  output logic [ROBEN_W-1:0]           cdb_ROBEN,
  output logic                         cdb_exception,
  input  logic                         cdb_grant,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic               exception;
    logic [ROBEN_W-1:0] roben;
    logic [DATA_W-1:0]  result;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   head_q;
  logic [PTR_W-1:0]   tail_q;
  logic [CNT_W-1:0]   count_q;

  entry_t             in_entry;
  entry_t             head_entry;
  entry_t             out_entry;
  logic               push_req;
  logic               do_push;
  logic               do_pop;

  assign in_entry   = '{exception: in_flow, roben: in_ROBEN, result: in_result};
  assign head_entry = mem[head_q];
  assign in_ready   = (count_q != CNT_W'(DEPTH));
  assign push_req   = in_valid && in_ready && (in_ROBEN != ROBEN_W'(NULL_ROBEN));

`ifdef FU_RESULT_BUFFER_BYPASS_EN
  logic bypass;

  // An empty queue forwards the incoming result; if granted it is never stored.
  assign bypass    = (count_q == '0) && push_req && !flush;
  assign cdb_valid = !flush && (bypass || (count_q != '0));
  assign out_entry = bypass ? in_entry : head_entry;
  assign do_push   = push_req && !(bypass && cdb_grant);
  assign do_pop    = (count_q != '0) && cdb_grant;
`else
  assign cdb_valid = (count_q != '0);
  assign out_entry = head_entry;
  assign do_push   = push_req;
  assign do_pop    = cdb_valid && cdb_grant;
`endif

  assign cdb_result    = out_entry.result;
  assign cdb_ROBEN     = out_entry.roben;
  assign cdb_exception = out_entry.exception;
  assign count         = count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      // Flush outranks any push or pop presented in the same cycle.
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem[tail_q] <= in_entry;
        tail_q      <= tail_q + PTR_W'(1);
      end
      if (do_pop) begin
        head_q <= head_q + PTR_W'(1);
      end
      if (do_push && !do_pop) begin
        count_q <= count_q + CNT_W'(1);
      end else if (!do_push && do_pop) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

endmodule

// File: doc/fu_result_buffer.md
Name: fu_result_buffer

Overview:
- Sits between an execution unit's output (adder/ALU: result, ROBEN, overflow flag) and the common data bus (CDB) arbiter.
- Captures each completed operation into a small in-order queue and holds it until the CDB arbiter grants a broadcast slot.
- Decouples fixed-latency functional units from CDB contention, so the unit never stalls on a lost arbitration unless the queue is full.

Parameters:
- DEPTH, 4, number of queued results; power of two, minimum 2.
- DATA_W, 32, result width.
- ROBEN_W, 5, reorder-buffer entry tag width; tag 0 means "no instruction".

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous clear on misprediction or exception.
- in_valid  in  1  functional unit presents a result.
- in_result  in  DATA_W  result value.
- in_ROBEN  in  ROBEN_W  destination ROB tag.
- in_flow  in  1  overflow flag from the unit.
- in_ready  out  1  queue can accept this cycle.
- cdb_valid  out  1  head entry is being offered to the CDB.
- cdb_result  out  DATA_W  head result.
- cdb_ROBEN  out  ROBEN_W  head tag.
- cdb_exception  out  1  head overflow flag.
- cdb_grant  in  1  arbiter accepts the head this cycle.
- count  out  $clog2(DEPTH+1)  occupancy.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - head pointer, tail pointer and count go to 0; all entry registers go to 0.
  - cdb_valid=0, cdb_result=0, cdb_ROBEN=0, cdb_exception=0; in_ready=1.
  - Pops and pushes stop immediately.
- Push:
  - occurs when in_valid && in_ready && in_ROBEN!=0.
  - in_valid with in_ROBEN==0 is ignored (no push, no error).
- in_ready = (count != DEPTH). There is no combinational dependence on cdb_grant, so a full queue refuses input even in a cycle where it pops.
- Pop:
  - occurs when cdb_valid && cdb_grant.
  - cdb_grant while cdb_valid=0 is ignored.
- Show-ahead head: cdb_* outputs are driven from the head entry; cdb_valid = (count != 0).
- Latency: a push at edge N is visible on cdb_valid after edge N (one cycle), provided the queue was empty.
- Ordering is strict FIFO; entries are never reordered.
- Simultaneous push and pop: both take effect; count is unchanged. On an empty queue only the push applies, because a pop requires cdb_valid.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count distinguishes full from empty.
- flush:
  - clears the pointers and count on the next edge.
  - has priority over a push and a pop in the same cycle; a result presented that cycle is discarded.
  - cdb_valid=0 from the next cycle.
- cdb_exception is the stored in_flow, passed through unchanged; the buffer does not interpret it.
- cdb_result, cdb_ROBEN and cdb_exception are held stable while cdb_valid=1 and no grant is given.

Optional Feature:
- Macro: FU_RESULT_BUFFER_BYPASS_EN.
- Defined:
  - When the queue is empty (count==0) and a result would be pushed, the in_* values drive the cdb_* outputs combinationally and cdb_valid=1 in the same cycle.
  - If cdb_grant=1 that cycle, the entry is consumed and not stored (zero latency). Otherwise it is pushed normally.
  - flush still blocks the bypass: cdb_valid=0 whenever flush=1.
- Undefined: the one-cycle registered latency described above always applies.

Decomposition:
- Shared header/package:
  - DATA_W and ROBEN_W defaults, used by all functional units and the CDB.
  - the NULL_ROBEN constant (0).
  - the CDB entry field layout {exception, ROBEN, result}.
- No sub-module. Storage is an inline register array with head and tail pointers. The CDB arbiter that drives cdb_grant is a separate block outside this one.

Test Plan:
- Reset, then push result 32'h0AAAA35E, ROBEN 4, flow 0 -> next cycle cdb_valid=1, cdb_result=32'h0AAAA35E, cdb_ROBEN=4, cdb_exception=0. Grant -> cdb_valid=0, count=0.
- Push 32'h80000000, ROBEN 16, flow 1 (0x7FFFFFFF+1) -> cdb_exception=1, cdb_ROBEN=16.
- Push ROBEN 1,2,3,4 with no grant -> count=4, in_ready=0; a fifth push with ROBEN 5 is dropped. Four grants then return 1,2,3,4 in order; count=0.
- With count=2, push ROBEN 7 and grant in the same cycle -> count stays 2; the head advances; ROBEN 7 emerges last.
- With count=3, assert flush together with in_valid (ROBEN 9) -> next cycle count=0, cdb_valid=0; ROBEN 9 never appears.
- Assert rst asynchronously between edges with count=2 -> cdb_valid drops immediately, count=0. After release, a push with ROBEN 0 is ignored (count stays 0).
